mips_sort_sched: RTL
====================

MIPS_SORT_SCHED -- requirements
Module: mips_sort_sched

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter IDW, default clog2(NREQ), SHALL set the width of the requester id.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the watchdog limit in clk cycles.
REQ-004 clk  in  1  SHALL be the clock; all state changes on its rising edge.
REQ-005 rstn  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 req_valid  in  NREQ  SHALL flag, per requester, that a sort job is pending.
REQ-007 req_ready  out  NREQ  SHALL be the one-hot job acceptance.
REQ-008 req_data  in  NREQ*256  SHALL carry job data: requester i at [256i+255:256i], word k at [32k+31:32k].
REQ-009 rsp_valid  out  1, rsp_ready  in  1 SHALL form the result handshake.
REQ-010 rsp_id  out  IDW, rsp_data  out  256, rsp_ninst  out  32, rsp_err  out  1 SHALL carry the result fields.
REQ-011 core_start  out  1, core_a  out  256 SHALL drive the sort engine: one-cycle start pulse plus 8 input words.
REQ-012 core_out  in  256, core_ninst  in  32, core_done  in  1 SHALL be the sort engine results; core_done is a one-cycle pulse.
REQ-013 busy  out  1 SHALL be high whenever the state is not IDLE.

Function
REQ-014 The block SHALL use the FSM states IDLE, LAUNCH, WAIT and RESP.
REQ-015 IDLE: req_ready SHALL be combinational and one-hot on the first set req_valid bit, searching from ptr upward modulo NREQ.
REQ-016 IDLE: req_ready SHALL be all-zero when no req_valid bit is set.
REQ-017 On acceptance (req_valid[g] & req_ready[g]) the block SHALL register req_data[g] into core_a and g into rsp_id.
REQ-018 On acceptance the block SHALL set ptr to (g+1) mod NREQ and go to LAUNCH.
REQ-019 LAUNCH: core_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT; core_start SHALL be 0 in every other state.
REQ-020 WAIT: on core_done=1, core_out and core_ninst SHALL be registered into rsp_data and rsp_ninst, rsp_err SHALL be set to 0, and the FSM SHALL go to RESP.
REQ-021 RESP: rsp_valid SHALL be 1 and all rsp_* fields SHALL be held stable until rsp_ready=1.
REQ-022 RESP: on rsp_ready=1 the FSM SHALL go to IDLE the next cycle, and no req_ready SHALL assert in that handshake cycle.
REQ-023 core_done outside WAIT SHALL be ignored.
REQ-024 Requesters SHALL hold req_valid and req_data stable until accepted; req_valid dropping before acceptance withdraws the job without side effects.
REQ-025 Latency SHALL be: acceptance at cycle T -> core_start at T+1; core_done at cycle D -> rsp_valid at D+1.
REQ-026 Exactly one job SHALL be in flight at any time.
REQ-027 core_a SHALL keep its value until the next acceptance.

Reset
REQ-028 On rstn=0 the block SHALL immediately set the state to IDLE and ptr to 0.
REQ-029 On rstn=0 core_start, rsp_valid and rsp_err SHALL be 0, and core_a, rsp_data, rsp_ninst and rsp_id SHALL be 0.
REQ-030 Reset asserted mid-job SHALL abandon the job with no response issued.
REQ-031 req_ready and busy SHALL be 0 while rstn=0.

Configuration
REQ-032 With MIPS_SORT_SCHED_TIMEOUT_EN defined, a WAIT cycle counter SHALL clear on entry to WAIT.
REQ-033 With the macro defined, the counter reaching TIMEOUT_CYCLES without core_done SHALL force RESP with rsp_err=1, rsp_data=0 and rsp_ninst=0; core_done in the same cycle SHALL win over the timeout.
REQ-034 Without MIPS_SORT_SCHED_TIMEOUT_EN, WAIT SHALL last until core_done, rsp_err SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-035 Reset, then requester 2 sends words 8,7,6,5,4,3,2,1 to an engine model returning ascending order after 300 cycles -> core_start 1 cycle after acceptance; rsp_valid with rsp_id=2, rsp_data=1..8, rsp_ninst=model value, rsp_err=0.
REQ-036 All four req_valid high at once, ptr=0 -> jobs granted in the order 0,1,2,3; afterwards a lone request from 0 plus 3 grants 0 first (ptr wrapped to 0).
REQ-037 rsp_ready held low for 5 cycles in RESP with req_valid[1]=1 -> rsp_* stable throughout, req_ready=0; grant to 1 only after the handshake.
REQ-038 Engine never returns core_done, macro defined -> rsp_err=1 and rsp_data=0 exactly TIMEOUT_CYCLES cycles after WAIT entry; core_done arriving later is ignored.
REQ-039 rstn pulsed low during WAIT -> all outputs 0 asynchronously; no response; the next request is accepted starting from ptr=0.
REQ-040 Stray core_done pulse while in IDLE -> no rsp_valid and no state change.

Source files
------------

// File: rtl/mips_sort_sched.sv
// mips_sort_sched: round-robin scheduler that feeds one sort job at a time to an external engine.
// Define MIPS_SORT_SCHED_TIMEOUT_EN to add a WAIT watchdog that returns an error response.
module mips_sort_sched #(
  parameter int NREQ           = 4,
  parameter int IDW            = $clog2(NREQ),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*256-1:0]  req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [255:0]         rsp_data,
  output logic [31:0]          rsp_ninst,
  output logic                 rsp_err,
  output logic                 core_start,
  output logic [255:0]         core_a,
  input  logic [255:0]         core_out,
  input  logic [31:0]          core_ninst,
  input  logic                 core_done,
  output logic                 busy
);

  localparam int SW = IDW + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t          state_reg;
  logic [IDW-1:0]  ptr_reg;
  logic [255:0]    core_a_reg;
  logic [IDW-1:0]  rsp_id_reg;
  logic [255:0]    rsp_data_reg;
  logic [31:0]     rsp_ninst_reg;
  logic            core_start_reg;
  logic            rsp_valid_reg;

  logic [255:0]    req_words [NREQ];
  logic [2*NREQ-1:0] dbl_valid;
  logic [NREQ-1:0] rot_valid;
  logic            found;
  logic [IDW-1:0]  offset;
  logic [SW-1:0]   grant_sum;
  logic [SW-1:0]   ptr_sum;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  ptr_next;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("mips_sort_sched: unsupported NREQ or TIMEOUT_CYCLES");
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
    assign req_words[gi] = req_data[gi*256 +: 256];
  end

  // Rotate so bit 0 is the requester at ptr; the lowest set bit is the winner.
  assign dbl_valid = {req_valid, req_valid} >> ptr_reg;
  assign rot_valid = dbl_valid[NREQ-1:0];

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        found  = 1'b1;
        offset = IDW'(k);
      end
    end
    grant_sum = {1'b0, ptr_reg} + {1'b0, offset};
    if (grant_sum >= SW'(NREQ)) grant_sum = grant_sum - SW'(NREQ);
    grant_idx = grant_sum[IDW-1:0];
    ptr_sum = {1'b0, grant_idx} + SW'(1);
    if (ptr_sum >= SW'(NREQ)) ptr_sum = '0;
    ptr_next = ptr_sum[IDW-1:0];
    req_ready = '0;
    if (rstn && state_reg == IDLE && found) req_ready = NREQ'(1) << grant_idx;
  end

`ifdef MIPS_SORT_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_reg;
  logic          rsp_err_reg;
  assign rsp_err = rsp_err_reg;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      core_a_reg     <= '0;
      rsp_id_reg     <= '0;
      rsp_data_reg   <= '0;
      rsp_ninst_reg  <= '0;
      core_start_reg <= 1'b0;
      rsp_valid_reg  <= 1'b0;
`ifdef MIPS_SORT_SCHED_TIMEOUT_EN
      wait_cnt_reg   <= '0;
      rsp_err_reg    <= 1'b0;
`endif
    end else begin
      core_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (found) begin
            core_a_reg     <= req_words[grant_idx];
            rsp_id_reg     <= grant_idx;
            ptr_reg        <= ptr_next;
            core_start_reg <= 1'b1;
            state_reg      <= LAUNCH;
          end
        end
        LAUNCH: begin
          state_reg <= WAIT;
`ifdef MIPS_SORT_SCHED_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
        end
        WAIT: begin
          if (core_done) begin
            rsp_data_reg  <= core_out;
            rsp_ninst_reg <= core_ninst;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
`ifdef MIPS_SORT_SCHED_TIMEOUT_EN
            rsp_err_reg   <= 1'b0;
          end else if (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
            // Response appears exactly TIMEOUT_CYCLES cycles after WAIT entry.
            rsp_data_reg  <= '0;
            rsp_ninst_reg <= '0;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            wait_cnt_reg  <= wait_cnt_reg + CW'(1);
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign core_start = core_start_reg;
  assign core_a     = core_a_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_ninst  = rsp_ninst_reg;
  assign busy       = (state_reg != IDLE);

endmodule
